// File: rtl/display_hdmi_vga_gen_v3.sv
// Programmable raster timing generator for HDMI/VGA style displays.
//
// Ports:
//   in_pclk          pixel clock (only clock)
//   in_rst           synchronous active-high reset
//   in_en            run enable; dropping it finishes the current frame, then idles
//   in_cfg_load      one-cycle pulse capturing all in_cfg_* into the pending set
//   in_cfg_h_*       horizontal sync/back-porch/active/front-porch widths (PW bits)
//   in_cfg_v_*       vertical sync/back-porch/active/front-porch heights (LW bits)
//   in_cfg_p_cnt     pixel-repeat factor, 0 behaves as 1
//   in_cfg_hs_pol    horizontal sync active level
//   in_cfg_vs_pol    vertical sync active level
//   out_x / out_y    active pixel / line index
//   out_valid        pixel strobe (first cycle of each repeated pixel)
//   out_de           data enable
//   out_hs / out_vs  syncs with polarity applied
//   out_sof          start of frame (x=0, y=0)
//   out_cfg_pending  a loaded config waits for the next frame boundary
//   out_cfg_err      one-cycle pulse when a load was rejected
// Counter state reaches the outputs through two register stages.
module display_hdmi_vga_gen_v3 #(
    parameter int unsigned PW     = 14,
    parameter int unsigned LW     = 12,
    parameter int unsigned H_SYNC = 96,
    parameter int unsigned H_BP   = 48,
    parameter int unsigned H_ACT  = 640,
    parameter int unsigned H_FP   = 16,
    parameter int unsigned V_SYNC = 2,
    parameter int unsigned V_BP   = 33,
    parameter int unsigned V_ACT  = 480,
    parameter int unsigned V_FP   = 10,
    parameter int unsigned P_CNT  = 1,
    parameter bit          HS_POL = 1'b0,
    parameter bit          VS_POL = 1'b0
) (
    input  logic          in_pclk,
    input  logic          in_rst,
    input  logic          in_en,
    input  logic          in_cfg_load,
    input  logic [PW-1:0] in_cfg_h_sync,
    input  logic [PW-1:0] in_cfg_h_bp,
    input  logic [PW-1:0] in_cfg_h_act,
    input  logic [PW-1:0] in_cfg_h_fp,
    input  logic [LW-1:0] in_cfg_v_sync,
    input  logic [LW-1:0] in_cfg_v_bp,
    input  logic [LW-1:0] in_cfg_v_act,
    input  logic [LW-1:0] in_cfg_v_fp,
    input  logic [2:0]    in_cfg_p_cnt,
    input  logic          in_cfg_hs_pol,
    input  logic          in_cfg_vs_pol,
    output logic [PW-1:0] out_x,
    output logic [LW-1:0] out_y,
    output logic          out_valid,
    output logic          out_de,
    output logic          out_hs,
    output logic          out_vs,
    output logic          out_sof,
    output logic          out_cfg_pending,
    output logic          out_cfg_err
);
    // Two guard bits: a sum of four fields can need up to width+2 bits.
    localparam int unsigned HW = PW + 2;
    localparam int unsigned VW = LW + 2;

    typedef struct packed {
        logic [PW-1:0] h_sync;
        logic [PW-1:0] h_bp;
        logic [PW-1:0] h_act;
        logic [PW-1:0] h_fp;
        logic [LW-1:0] v_sync;
        logic [LW-1:0] v_bp;
        logic [LW-1:0] v_act;
        logic [LW-1:0] v_fp;
        logic [2:0]    p_cnt;   // always stored as the effective factor (1..7)
        logic          hs_pol;
        logic          vs_pol;
    } cfg_t;

    localparam logic [2:0] P_EFF = (P_CNT == 0) ? 3'd1 : 3'(P_CNT);
    localparam cfg_t PARAM_CFG = '{
        h_sync: PW'(H_SYNC), h_bp: PW'(H_BP), h_act: PW'(H_ACT), h_fp: PW'(H_FP),
        v_sync: LW'(V_SYNC), v_bp: LW'(V_BP), v_act: LW'(V_ACT), v_fp: LW'(V_FP),
        p_cnt: P_EFF, hs_pol: HS_POL, vs_pol: VS_POL
    };

    typedef enum logic [1:0] {StIdle, StRun, StStop} state_e;

    state_e        state_q, state_d;
    cfg_t          act_q, pend_q, in_cfg;
    logic          pend_v_q, err_q;
    logic [PW-1:0] x_q, x_d;
    logic [LW-1:0] y_q, y_d;
    logic [2:0]    rep1_q, rep_d;
    logic [PW-1:0] px1_q, px_d;
    logic [PW-1:0] s1_x;
    logic [LW-1:0] s1_y;
    logic          s1_valid, s1_de, s1_hs, s1_vs, s1_sof;

    // Incoming config validation.
    logic [HW-1:0] in_ht;
    logic [VW-1:0] in_vt;
    logic          in_cfg_ok, load_ok;

    assign in_cfg = '{
        h_sync: in_cfg_h_sync, h_bp: in_cfg_h_bp, h_act: in_cfg_h_act, h_fp: in_cfg_h_fp,
        v_sync: in_cfg_v_sync, v_bp: in_cfg_v_bp, v_act: in_cfg_v_act, v_fp: in_cfg_v_fp,
        p_cnt: (in_cfg_p_cnt == 3'd0) ? 3'd1 : in_cfg_p_cnt,
        hs_pol: in_cfg_hs_pol, vs_pol: in_cfg_vs_pol
    };
    assign in_ht = HW'(in_cfg_h_sync) + HW'(in_cfg_h_bp) + HW'(in_cfg_h_act) + HW'(in_cfg_h_fp);
    assign in_vt = VW'(in_cfg_v_sync) + VW'(in_cfg_v_bp) + VW'(in_cfg_v_act) + VW'(in_cfg_v_fp);
    assign in_cfg_ok = (in_cfg_h_sync != '0) && (in_cfg_h_act != '0) &&
                       (in_cfg_v_sync != '0) && (in_cfg_v_act != '0) &&
                       (in_ht[HW-1:PW] == '0) && (in_vt[VW-1:LW] == '0);
    assign load_ok = in_cfg_load && in_cfg_ok;

    // Active timing boundaries.
    logic [HW-1:0] h_de_start, h_de_end, ht, x_ext;
    logic [VW-1:0] v_de_start, v_de_end, vt, y_ext;
    logic          run, x_last, y_last, frame_last, apply;
    logic          hs_raw, vs_raw, de_raw;

    assign h_de_start = HW'(act_q.h_sync) + HW'(act_q.h_bp);
    assign h_de_end   = h_de_start + HW'(act_q.h_act);
    assign ht         = h_de_end + HW'(act_q.h_fp);
    assign v_de_start = VW'(act_q.v_sync) + VW'(act_q.v_bp);
    assign v_de_end   = v_de_start + VW'(act_q.v_act);
    assign vt         = v_de_end + VW'(act_q.v_fp);
    assign x_ext      = HW'(x_q);
    assign y_ext      = VW'(y_q);

    assign run        = (state_q != StIdle);
    assign x_last     = (x_ext == ht - HW'(1));
    assign y_last     = (y_ext == vt - VW'(1));
    assign frame_last = run && x_last && y_last;
    // Pending config switches in on the frame's last cycle, or immediately when idle.
    assign apply      = pend_v_q && (!run || frame_last);

    assign hs_raw = x_ext < HW'(act_q.h_sync);
    assign vs_raw = y_ext < VW'(act_q.v_sync);
    assign de_raw = run && (x_ext >= h_de_start) && (x_ext < h_de_end) &&
                    (y_ext >= v_de_start) && (y_ext < v_de_end);

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        unique case (state_q)
            StIdle: if (in_en) state_d = StRun;
            StRun:  if (!in_en) state_d = StStop;
            StStop: begin
                if (in_en) state_d = StRun;
                else if (frame_last) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (!run) begin
            x_d = '0;
            y_d = '0;
        end else if (x_last) begin
            x_d = '0;
            y_d = y_last ? '0 : y_q + LW'(1);
        end else begin
            x_d = x_q + PW'(1);
        end
    end

    // Repeat phase and pixel index replace n mod P / n div P; both restart on the
    // first active cycle of every line.
    always_comb begin
        rep_d = '0;
        px_d  = '0;
        if (de_raw && (x_ext != h_de_start)) begin
            if (rep1_q == act_q.p_cnt - 3'd1) begin
                rep_d = '0;
                px_d  = px1_q + PW'(1);
            end else begin
                rep_d = rep1_q + 3'd1;
                px_d  = px1_q;
            end
        end
    end

    always_ff @(posedge in_pclk) begin
        if (in_rst) begin
            state_q   <= StIdle;
            x_q       <= '0;
            y_q       <= '0;
            act_q     <= PARAM_CFG;
            pend_q    <= PARAM_CFG;
            pend_v_q  <= 1'b0;
            err_q     <= 1'b0;
            rep1_q    <= '0;
            px1_q     <= '0;
            s1_x      <= '0;
            s1_y      <= '0;
            s1_valid  <= 1'b0;
            s1_de     <= 1'b0;
            s1_hs     <= ~HS_POL;
            s1_vs     <= ~VS_POL;
            s1_sof    <= 1'b0;
            out_x     <= '0;
            out_y     <= '0;
            out_valid <= 1'b0;
            out_de    <= 1'b0;
            out_hs    <= ~HS_POL;
            out_vs    <= ~VS_POL;
            out_sof   <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            err_q    <= in_cfg_load && !in_cfg_ok;
            if (apply) act_q <= pend_q;
            // A load on the apply edge lands in pending and waits for the next boundary.
            if (load_ok) pend_q <= in_cfg;
            pend_v_q <= load_ok || (pend_v_q && !apply);

            rep1_q   <= rep_d;
            px1_q    <= px_d;
            s1_de    <= de_raw;
            s1_valid <= de_raw && (rep_d == 3'd0);
            s1_x     <= de_raw ? px_d : '0;
            s1_y     <= de_raw ? LW'(y_ext - v_de_start) : '0;
            s1_hs    <= (run && hs_raw) ? act_q.hs_pol : ~act_q.hs_pol;
            s1_vs    <= (run && vs_raw) ? act_q.vs_pol : ~act_q.vs_pol;
            s1_sof   <= run && (x_q == '0) && (y_q == '0);

            out_x     <= s1_x;
            out_y     <= s1_y;
            out_valid <= s1_valid;
            out_de    <= s1_de;
            out_hs    <= s1_hs;
            out_vs    <= s1_vs;
            out_sof   <= s1_sof;
        end
    end

    assign out_cfg_pending = pend_v_q;
    assign out_cfg_err     = err_q;

endmodule

// File: tb/tb_display_hdmi_vga_gen_v3.sv
module tb_display_hdmi_vga_gen_v3;
    localparam int unsigned PW = 8;
    localparam int unsigned LW = 6;
    localparam int P_HS = 3, P_HB = 2, P_HA = 5, P_HF = 2;
    localparam int P_VS = 2, P_VB = 1, P_VA = 3, P_VF = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic          load = 1'b0;
    logic [PW-1:0] h_sync = '0, h_bp = '0, h_act = '0, h_fp = '0;
    logic [LW-1:0] v_sync = '0, v_bp = '0, v_act = '0, v_fp = '0;
    logic [2:0]    p_cnt = '0;
    logic          hs_pol = 1'b0, vs_pol = 1'b0;
    logic [PW-1:0] out_x;
    logic [LW-1:0] out_y;
    logic          out_valid, out_de, out_hs, out_vs, out_sof, out_cfg_pending, out_cfg_err;

    always #5 clk = ~clk;

    display_hdmi_vga_gen_v3 #(
        .PW(PW), .LW(LW),
        .H_SYNC(P_HS), .H_BP(P_HB), .H_ACT(P_HA), .H_FP(P_HF),
        .V_SYNC(P_VS), .V_BP(P_VB), .V_ACT(P_VA), .V_FP(P_VF),
        .P_CNT(1), .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut (
        .in_pclk(clk), .in_rst(rst), .in_en(en), .in_cfg_load(load),
        .in_cfg_h_sync(h_sync), .in_cfg_h_bp(h_bp), .in_cfg_h_act(h_act), .in_cfg_h_fp(h_fp),
        .in_cfg_v_sync(v_sync), .in_cfg_v_bp(v_bp), .in_cfg_v_act(v_act), .in_cfg_v_fp(v_fp),
        .in_cfg_p_cnt(p_cnt), .in_cfg_hs_pol(hs_pol), .in_cfg_vs_pol(vs_pol),
        .out_x(out_x), .out_y(out_y), .out_valid(out_valid), .out_de(out_de),
        .out_hs(out_hs), .out_vs(out_vs), .out_sof(out_sof),
        .out_cfg_pending(out_cfg_pending), .out_cfg_err(out_cfg_err)
    );

    typedef struct {
        int hs, hb, ha, hf, vs, vb, va, vf, p;
        bit hp, vp;
    } mcfg_t;

    typedef struct packed {
        logic [PW-1:0] x;
        logic [LW-1:0] y;
        logic          valid, de, hs, vs, sof;
    } mout_t;

    int checks = 0;
    int failures = 0;

    function automatic mcfg_t param_cfg();
        mcfg_t c;
        c = '{hs: P_HS, hb: P_HB, ha: P_HA, hf: P_HF, vs: P_VS, vb: P_VB, va: P_VA, vf: P_VF,
              p: 1, hp: 1'b0, vp: 1'b0};
        return c;
    endfunction

    function automatic mcfg_t input_cfg();
        mcfg_t c;
        c = '{hs: int'(h_sync), hb: int'(h_bp), ha: int'(h_act), hf: int'(h_fp),
              vs: int'(v_sync), vb: int'(v_bp), va: int'(v_act), vf: int'(v_fp),
              p: int'(p_cnt), hp: hs_pol, vp: vs_pol};
        return c;
    endfunction

    function automatic bit cfg_ok(mcfg_t c);
        return c.hs != 0 && c.ha != 0 && c.vs != 0 && c.va != 0 &&
               (c.hs + c.hb + c.ha + c.hf) <= (1 << PW) - 1 &&
               (c.vs + c.vb + c.va + c.vf) <= (1 << LW) - 1;
    endfunction

    // What the outputs must show for a raster position, straight from the timing rules.
    function automatic mout_t decode(bit running, int x, int y, mcfg_t c);
        mout_t o;
        int    n, p;
        p = (c.p == 0) ? 1 : c.p;
        o = '0;
        o.hs  = (running && x < c.hs) ? c.hp : !c.hp;
        o.vs  = (running && y < c.vs) ? c.vp : !c.vp;
        o.sof = running && x == 0 && y == 0;
        o.de  = running && x >= c.hs + c.hb && x < c.hs + c.hb + c.ha &&
                y >= c.vs + c.vb && y < c.vs + c.vb + c.va;
        if (o.de) begin
            n       = x - (c.hs + c.hb);
            o.valid = (n % p) == 0;
            o.x     = PW'(n / p);
            o.y     = LW'(y - (c.vs + c.vb));
        end
        return o;
    endfunction

    // Reference model: mode 0 idle, 1 run, 2 stop; m_s1/m_s2 give the 2-cycle latency.
    mcfg_t m_act, m_pend;
    bit    m_pend_v, m_err;
    int    m_mode, m_x, m_y;
    mout_t m_s1, m_s2, got;

    initial begin
        mcfg_t inc;
        bit    last;
        int    ht, vt;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_mode = 0; m_x = 0; m_y = 0;
                m_act = param_cfg(); m_pend_v = 1'b0; m_err = 1'b0;
                m_s1 = decode(1'b0, 0, 0, m_act);
                m_s2 = m_s1;
            end else begin
                ht   = m_act.hs + m_act.hb + m_act.ha + m_act.hf;
                vt   = m_act.vs + m_act.vb + m_act.va + m_act.vf;
                last = m_mode != 0 && m_x == ht - 1 && m_y == vt - 1;
                m_s2 = m_s1;
                m_s1 = decode(m_mode != 0, m_x, m_y, m_act);
                inc  = input_cfg();
                m_err = load && !cfg_ok(inc);
                if (m_pend_v && (m_mode == 0 || last)) begin
                    m_act = m_pend;
                    m_pend_v = 1'b0;
                end
                if (load && cfg_ok(inc)) begin
                    m_pend = inc;
                    m_pend_v = 1'b1;
                end
                if (m_mode == 0) begin
                    m_x = 0; m_y = 0;
                    if (en) m_mode = 1;
                end else begin
                    if (m_x == ht - 1) begin
                        m_x = 0;
                        m_y = (m_y == vt - 1) ? 0 : m_y + 1;
                    end else begin
                        m_x = m_x + 1;
                    end
                    if (m_mode == 1) begin
                        if (!en) m_mode = 2;
                    end else if (en) begin
                        m_mode = 1;
                    end else if (last) begin
                        m_mode = 0;
                    end
                end
            end
            #1;
            got = {out_x, out_y, out_valid, out_de, out_hs, out_vs, out_sof};
            checks++;
            if (got !== m_s2 || out_cfg_pending !== m_pend_v || out_cfg_err !== m_err) begin
                failures++;
                if (failures <= 20)
                    $display("FAIL cycle_compare t=%0t got x=%0d y=%0d v=%b de=%b hs=%b vs=%b sof=%b pend=%b err=%b required x=%0d y=%0d v=%b de=%b hs=%b vs=%b sof=%b pend=%b err=%b",
                             $time, out_x, out_y, out_valid, out_de, out_hs, out_vs, out_sof,
                             out_cfg_pending, out_cfg_err, m_s2.x, m_s2.y, m_s2.valid, m_s2.de,
                             m_s2.hs, m_s2.vs, m_s2.sof, m_pend_v, m_err);
            end
        end
    end

    task automatic chk(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s got=%0d required=%0d", name, actual, expected);
        end
    endtask

    task automatic do_load(input int hs, hb, ha, hf, vs, vb, va, vf, p, input bit hp, vp);
        @(negedge clk);
        h_sync = PW'(hs); h_bp = PW'(hb); h_act = PW'(ha); h_fp = PW'(hf);
        v_sync = LW'(vs); v_bp = LW'(vb); v_act = LW'(va); v_fp = LW'(vf);
        p_cnt = 3'(p); hs_pol = hp; vs_pol = vp;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_applied(input int budget);
        int i;
        i = 0;
        while (out_cfg_pending && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk("apply_within_budget", int'(out_cfg_pending), 0);
    endtask

    task automatic stats(input int n, output int sof_c, output int de_c, output int val_c,
                         output int hs_hi, output int vs_lo, output int max_x);
        sof_c = 0; de_c = 0; val_c = 0; hs_hi = 0; vs_lo = 0; max_x = 0;
        repeat (n) begin
            @(negedge clk);
            sof_c += int'(out_sof);
            de_c  += int'(out_de);
            val_c += int'(out_valid);
            hs_hi += int'(out_hs);
            vs_lo += int'(!out_vs);
            if (out_valid && int'(out_x) > max_x) max_x = int'(out_x);
        end
    endtask

    initial begin
        int s, d, v, hh, vl, mx, e;
        repeat (3) @(negedge clk);
        chk("reset_de", int'(out_de), 0);
        chk("reset_hs_inactive", int'(out_hs), 1);
        chk("reset_pending", int'(out_cfg_pending), 0);
        rst = 1'b0;

        // HT=10, VT=5, P=1, hs active-high, vs active-low.
        do_load(2, 2, 4, 2, 1, 1, 2, 1, 1, 1'b1, 1'b0);
        repeat (5) @(negedge clk);
        chk("idle_hs_low", int'(out_hs), 0);
        chk("idle_vs_high", int'(out_vs), 1);
        en = 1'b1;
        repeat (10) @(negedge clk);
        stats(200, s, d, v, hh, vl, mx);
        chk("p1_sof", s, 4);
        chk("p1_de", d, 32);
        chk("p1_valid", v, 32);
        chk("p1_hs_high", hh, 40);
        chk("p1_vs_low", vl, 40);
        chk("p1_max_x", mx, 3);

        do_load(2, 2, 4, 2, 1, 1, 2, 1, 2, 1'b1, 1'b0);
        wait_applied(200);
        repeat (5) @(negedge clk);
        stats(200, s, d, v, hh, vl, mx);
        chk("p2_sof", s, 4);
        chk("p2_de", d, 32);
        chk("p2_valid", v, 16);
        chk("p2_max_x", mx, 1);

        do_load(2, 2, 0, 2, 1, 1, 2, 1, 1, 1'b1, 1'b0);
        e = int'(out_cfg_err);
        repeat (4) begin
            @(negedge clk);
            e += int'(out_cfg_err);
        end
        chk("bad_load_err_pulses", e, 1);
        chk("bad_load_no_pending", int'(out_cfg_pending), 0);

        do_load(2, 2, 6, 2, 1, 1, 2, 1, 1, 1'b1, 1'b0);
        chk("act6_pending", int'(out_cfg_pending), 1);
        wait_applied(200);
        repeat (5) @(negedge clk);
        stats(240, s, d, v, hh, vl, mx);
        chk("act6_sof", s, 4);
        chk("act6_de", d, 48);
        chk("act6_max_x", mx, 5);

        @(negedge clk);
        en = 1'b0;
        repeat (150) @(negedge clk);
        stats(60, s, d, v, hh, vl, mx);
        chk("stopped_de", d, 0);
        chk("stopped_sof", s, 0);

        en = 1'b1;
        repeat (25) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midreset_de", int'(out_de), 0);
        chk("midreset_hs_param_pol", int'(out_hs), 1);
        repeat (10) @(negedge clk);
        // Parameter timing: HT=12, VT=7, frame 84 cycles.
        stats(168, s, d, v, hh, vl, mx);
        chk("param_sof", s, 2);
        chk("param_de", d, 30);
        chk("param_hs_high", hh, 126);
        chk("param_vs_low", vl, 48);
        chk("param_max_x", mx, 4);

        repeat (15000) begin
            @(negedge clk);
            load = 1'b0;
            rst  = 1'b0;
            if ($urandom_range(0, 99) == 0) en = ~en;
            if ($urandom_range(0, 59) == 0) begin
                h_sync = PW'($urandom_range(0, 4)); h_bp = PW'($urandom_range(0, 4));
                h_act  = PW'($urandom_range(0, 4)); h_fp = PW'($urandom_range(0, 4));
                v_sync = LW'($urandom_range(0, 3)); v_bp = LW'($urandom_range(0, 3));
                v_act  = LW'($urandom_range(0, 3)); v_fp = LW'($urandom_range(0, 3));
                if ($urandom_range(0, 9) == 0) h_fp = PW'(254);
                if ($urandom_range(0, 9) == 0) v_fp = LW'(62);
                p_cnt  = 3'($urandom_range(0, 7));
                hs_pol = 1'($urandom_range(0, 1));
                vs_pol = 1'($urandom_range(0, 1));
                load   = 1'b1;
            end
            if ($urandom_range(0, 2999) == 0) rst = 1'b1;
        end
        @(negedge clk);
        load = 1'b0;
        rst  = 1'b0;
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
